// File: rtl/fft_pkg.sv
// Shared FFT constants and the twiddle sequencer state encoding.
// Defaults describe a 1024-point radix-2 in-place DIT transform.
package fft_pkg;
    localparam int LOG2N      = 10;
    localparam int ADDR_WIDTH = LOG2N - 1;
    localparam int DATA_WIDTH = 48;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_GAP   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;
endpackage

// File: rtl/twiddle_sequencer.sv
// Walks all radix-2 DIT butterflies, driving the twiddle ROM address and the pair indices.
// Pair indices are valid one cycle after an issue, aligned with ROM data; bfly_ready low holds every issue register.
module twiddle_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N      = fft_pkg::LOG2N,
    parameter int ADDR_WIDTH = fft_pkg::ADDR_WIDTH,
    parameter int STAGE_GAP  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  bfly_ready,
    output logic [ADDR_WIDTH-1:0] tw_addr,
    output logic                  issue_valid,
    output logic [LOG2N-1:0]      idx_a,
    output logic [LOG2N-1:0]      idx_b,
    output logic [3:0]            stage,
    output logic                  pair_valid,
    output logic                  busy,
    output logic                  done
);
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    seq_state_e            state, state_next;
    logic [3:0]            s;
    logic [ADDR_WIDTH-1:0] j;
    logic [GW-1:0]         gap_cnt;

    logic                  fire;
    logic                  last_j, last_s, gap_last;
    logic [ADDR_WIDTH-1:0] hmask, pos, grp, pos_next, tw_next;
    logic [3:0]            tw_shift;
    logic [LOG2N-1:0]      cur_a, cur_b;

    assign last_j   = (j == {ADDR_WIDTH{1'b1}});
    assign last_s   = (s == 4'(LOG2N - 1));
    assign gap_last = (gap_cnt == GW'(STAGE_GAP - 1));
    assign fire     = issue_valid & bfly_ready;

    // h-1 wraps to all ones on the final stage, where every j is its own position.
    assign hmask    = (ADDR_WIDTH'(1) << s) - ADDR_WIDTH'(1);
    assign pos      = j & hmask;
    assign grp      = j >> s;
    assign cur_a    = (LOG2N'(grp) << (s + 4'd1)) | LOG2N'(pos);
    assign cur_b    = cur_a + (LOG2N'(1) << s);
    assign tw_shift = 4'(LOG2N - 1) - s;
    assign pos_next = (j + ADDR_WIDTH'(1)) & hmask;
    assign tw_next  = pos_next << tw_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        issue_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                issue_valid = 1'b1;
                busy        = 1'b1;
                if (bfly_ready && last_j) begin
                    if (last_s)              state_next = ST_FLUSH;
                    else if (STAGE_GAP != 0) state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                busy = 1'b1;
                if (gap_last) state_next = ST_RUN;
            end
            ST_FLUSH: begin
                busy       = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The next pair's ROM address is registered at issue time so the ROM
    // sees a stable address for as long as the butterfly unit stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s          <= '0;
            j          <= '0;
            gap_cnt    <= '0;
            tw_addr    <= '0;
            idx_a      <= '0;
            idx_b      <= '0;
            stage      <= '0;
            pair_valid <= 1'b0;
        end else begin
            pair_valid <= fire;
            if (fire) begin
                idx_a <= cur_a;
                idx_b <= cur_b;
                stage <= s;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        s       <= '0;
                        j       <= '0;
                        gap_cnt <= '0;
                        tw_addr <= '0;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        if (last_j) begin
                            j       <= '0;
                            tw_addr <= '0;
                            gap_cnt <= '0;
                            if (!last_s && STAGE_GAP == 0) s <= s + 4'd1;
                        end else begin
                            j       <= j + ADDR_WIDTH'(1);
                            tw_addr <= tw_next;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        s       <= s + 4'd1;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_twiddle_sequencer.sv
// Randomised-stall bench for twiddle_sequencer with a table-driven pair model and a behavioural twiddle ROM.
module tb_twiddle_sequencer;
    localparam int LOG2N     = 10;
    localparam int AW        = 9;
    localparam int STAGE_GAP = 4;
    localparam int HALF      = 1 << (LOG2N - 1);
    localparam int TOTAL     = LOG2N * HALF;
    localparam int EXP_CYC   = TOTAL + (LOG2N - 1) * STAGE_GAP + 2;
    localparam int BUDGET    = 20000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            bfly_ready = 1'b0;
    logic [AW-1:0]   tw_addr;
    logic            issue_valid;
    logic [LOG2N-1:0] idx_a, idx_b;
    logic [3:0]      stage;
    logic            pair_valid, busy, done;

    logic [47:0]     rom_mem [HALF];
    logic [47:0]     rom_q;

    int exp_a [TOTAL];
    int exp_b [TOTAL];
    int exp_s [TOTAL];
    int exp_tw[TOTAL];
    int got_a [TOTAL];
    int got_b [TOTAL];
    int got_tw[TOTAL];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom_mem[tw_addr];

    twiddle_sequencer #(.LOG2N(LOG2N), .ADDR_WIDTH(AW), .STAGE_GAP(STAGE_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bfly_ready(bfly_ready),
        .tw_addr(tw_addr), .issue_valid(issue_valid), .idx_a(idx_a), .idx_b(idx_b),
        .stage(stage), .pair_valid(pair_valid), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_tw"}, tw_addr, 0);
        chk({tag, "_iv"}, issue_valid, 0);
        chk({tag, "_a"}, idx_a, 0);
        chk({tag, "_b"}, idx_b, 0);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_pv"}, pair_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic spot_first_pairs();
        chk("s0j0_a", got_a[0], 0);
        chk("s0j0_b", got_b[0], 1);
        chk("s0j0_tw", got_tw[0], 0);
        chk("s0j1_a", got_a[1], 2);
        chk("s0j1_b", got_b[1], 3);
        chk("s0j1_tw", got_tw[1], 0);
    endtask

    task automatic spot_late_pairs();
        chk("s1j1_a", got_a[HALF + 1], 1);
        chk("s1j1_b", got_b[HALF + 1], 3);
        chk("s1j1_tw", got_tw[HALF + 1], 256);
        chk("s9j1_a", got_a[9 * HALF + 1], 1);
        chk("s9j1_b", got_b[9 * HALF + 1], 513);
        chk("s9j1_tw", got_tw[9 * HALF + 1], 1);
        chk("s9j511_a", got_a[TOTAL - 1], 511);
        chk("s9j511_b", got_b[TOTAL - 1], 1023);
        chk("s9j511_tw", got_tw[TOTAL - 1], 511);
    endtask

    // Called at #1 after a rising edge; returns at the same phase.
    task automatic run_fft(input int rdy_pct, input bit timed, input int abort_stg);
        int  n, fire_k, pv_k, zrun, last_stg;
        bit  prev_stall, got_done;
        logic [AW-1:0] prev_tw;
        fire_k = 0; pv_k = 0; zrun = 0; last_stg = -1;
        prev_stall = 0; got_done = 0; prev_tw = '0;
        for (int k = 0; k < TOTAL; k++) begin
            got_a[k] = -1; got_b[k] = -1; got_tw[k] = -1;
        end
        chk("busy_before_start", busy, 0);
        start = 1'b1;
        bfly_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        chk("busy_rise", busy, 1);
        while (n <= BUDGET) begin
            if (pair_valid) begin
                if (pv_k < TOTAL) begin
                    chk("pair_stage", stage, exp_s[pv_k]);
                    chk("pair_a", idx_a, exp_a[pv_k]);
                    chk("pair_b", idx_b, exp_b[pv_k]);
                    chk("pair_twiddle", rom_q, rom_mem[exp_tw[pv_k]]);
                    got_a[pv_k] = int'(idx_a);
                    got_b[pv_k] = int'(idx_b);
                end else begin
                    chk("pair_count", pv_k, TOTAL - 1);
                end
                if (timed && last_stg >= 0 && int'(stage) != last_stg)
                    chk("stage_gap", zrun, STAGE_GAP);
                last_stg = int'(stage);
                zrun = 0;
                pv_k++;
                if (abort_stg >= 0 && int'(stage) == abort_stg) begin
                    rst_n = 1'b0;
                    #1;
                    chk_idle_outputs("abort");
                    @(posedge clk); #1;
                    chk("abort_done", done, 0);
                    rst_n = 1'b1;
                    @(posedge clk); #1;
                    chk("abort_idle_busy", busy, 0);
                    chk("abort_idle_done", done, 0);
                    return;
                end
            end else if (last_stg >= 0) begin
                zrun++;
            end
            if (prev_stall) chk("tw_hold", tw_addr, prev_tw);
            if (issue_valid) begin
                if (fire_k < TOTAL) chk("tw_addr", tw_addr, exp_tw[fire_k]);
                else                chk("issue_count", fire_k, TOTAL - 1);
            end
            if (done) begin
                chk("done_pairs", pv_k, TOTAL);
                chk("done_fires", fire_k, TOTAL);
                chk("busy_fall", busy, 0);
                if (timed) chk("done_cycle", n, EXP_CYC);
                got_done = 1;
                break;
            end
            bfly_ready = ($urandom_range(0, 99) < rdy_pct);
            start = (abort_stg < 0) && ($urandom_range(0, 299) == 0);
            if (issue_valid && bfly_ready) begin
                if (fire_k < TOTAL) got_tw[fire_k] = int'(tw_addr);
                fire_k++;
            end
            prev_stall = issue_valid && !bfly_ready;
            prev_tw = tw_addr;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        bfly_ready = 1'b0;
        chk("done_seen", got_done, 1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("done_single", done, 0);
            chk("post_busy", busy, 0);
        end
    endtask

    initial begin
        for (int s = 0; s < LOG2N; s++) begin
            for (int j = 0; j < HALF; j++) begin
                int h, k;
                h = 1 << s;
                k = s * HALF + j;
                exp_s[k]  = s;
                exp_a[k]  = (j / h) * 2 * h + (j % h);
                exp_b[k]  = exp_a[k] + h;
                exp_tw[k] = (j % h) * (HALF / h);
            end
        end
        for (int i = 0; i < HALF; i++)
            rom_mem[i] = {16'($urandom), 32'($urandom)};

        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_fft(100, 1'b1, -1);
        spot_first_pairs();
        spot_late_pairs();

        run_fft(50, 1'b0, -1);
        spot_late_pairs();

        run_fft(100, 1'b0, 3);

        run_fft(100, 1'b1, -1);
        spot_first_pairs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
